// File: rtl/mem_stage_pkg.sv
// Shared CPU constants for the memory stage: instruction one-hot indices,
// bubble encoding, bypass-select encodings, reset PC and the Mem/WB record.
package mem_stage_pkg;

  localparam int          INSTR_W      = 60;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

  // One-hot bit positions within InstrType
  localparam int IDX_SLL  = 0;
  localparam int IDX_ADDU = 1;
  localparam int IDX_SUBU = 2;
  localparam int IDX_ORI  = 3;
  localparam int IDX_LUI  = 4;
  localparam int IDX_JAL  = 5;
  localparam int IDX_LW   = 20;
  localparam int IDX_LH   = 21;
  localparam int IDX_LHU  = 22;
  localparam int IDX_LB   = 23;
  localparam int IDX_LBU  = 24;
  localparam int IDX_SW   = 25;
  localparam int IDX_SH   = 26;
  localparam int IDX_SB   = 27;

  localparam logic [INSTR_W-1:0] INST_SLL = 60'd1 << IDX_SLL;

  localparam logic BYP_DM_EX = 1'b0;
  localparam logic BYP_DM_WB = 1'b1;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic [4:0]         raddr0;
    logic [4:0]         raddr1;
    logic [2:0]         tuse0;
    logic [2:0]         tuse1;
    logic [2:0]         tnew;
  } mem_wb_t;

  // Hazard counters count down one per stage and stop at zero
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v != 3'd0) ? v - 3'd1 : v;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/Mem inputs, Mem/WB outputs and hazard-unit taps of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [31:0]        PC_EX_to_Mem;
  logic [INSTR_W-1:0] InstrType_EX_to_Mem;
  logic [4:0]         RAddr0_EX_to_Mem;
  logic [4:0]         RAddr1_EX_to_Mem;
  logic [4:0]         RegWriteAddr_EX_to_Mem;
  logic [31:0]        ALUOut_EX_to_Mem;
  logic [31:0]        DMWriteData_EX_to_Mem;
  logic [2:0]         Tuse_RAddr0_EX_to_Mem;
  logic [2:0]         Tuse_RAddr1_EX_to_Mem;
  logic [2:0]         Tnew_WAddr_EX_to_Mem;
  logic [31:0]        bypass_WB;
  logic               DMWriteDataBypassCtrl_Mem;

  logic [31:0]        PC_Mem_to_WB;
  logic [INSTR_W-1:0] InstrType_Mem_to_WB;
  logic [4:0]         RegWriteAddr_Mem_to_WB;
  logic [31:0]        RegWriteData_Mem_to_WB;
  logic [4:0]         RAddr0_Mem_to_WB;
  logic [4:0]         RAddr1_Mem_to_WB;
  logic [2:0]         Tuse_RAddr0_Mem_to_WB;
  logic [2:0]         Tuse_RAddr1_Mem_to_WB;
  logic [2:0]         Tnew_WAddr_Mem_to_WB;

  logic [4:0]         RAddr0_Mem;
  logic [4:0]         RAddr1_Mem;
  logic [4:0]         RegWriteAddr_Mem;
  logic [2:0]         Tuse_RAddr0_Mem;
  logic [2:0]         Tuse_RAddr1_Mem;
  logic [2:0]         Tnew_WAddr_Mem;
  logic [31:0]        bypass_Mem_out;

  modport slave (
    input  PC_EX_to_Mem, InstrType_EX_to_Mem, RAddr0_EX_to_Mem, RAddr1_EX_to_Mem,
           RegWriteAddr_EX_to_Mem, ALUOut_EX_to_Mem, DMWriteData_EX_to_Mem,
           Tuse_RAddr0_EX_to_Mem, Tuse_RAddr1_EX_to_Mem, Tnew_WAddr_EX_to_Mem,
           bypass_WB, DMWriteDataBypassCtrl_Mem,
    output PC_Mem_to_WB, InstrType_Mem_to_WB, RegWriteAddr_Mem_to_WB,
           RegWriteData_Mem_to_WB, RAddr0_Mem_to_WB, RAddr1_Mem_to_WB,
           Tuse_RAddr0_Mem_to_WB, Tuse_RAddr1_Mem_to_WB, Tnew_WAddr_Mem_to_WB,
           RAddr0_Mem, RAddr1_Mem, RegWriteAddr_Mem,
           Tuse_RAddr0_Mem, Tuse_RAddr1_Mem, Tnew_WAddr_Mem, bypass_Mem_out
  );

  modport master (
    output PC_EX_to_Mem, InstrType_EX_to_Mem, RAddr0_EX_to_Mem, RAddr1_EX_to_Mem,
           RegWriteAddr_EX_to_Mem, ALUOut_EX_to_Mem, DMWriteData_EX_to_Mem,
           Tuse_RAddr0_EX_to_Mem, Tuse_RAddr1_EX_to_Mem, Tnew_WAddr_EX_to_Mem,
           bypass_WB, DMWriteDataBypassCtrl_Mem,
    input  PC_Mem_to_WB, InstrType_Mem_to_WB, RegWriteAddr_Mem_to_WB,
           RegWriteData_Mem_to_WB, RAddr0_Mem_to_WB, RAddr1_Mem_to_WB,
           Tuse_RAddr0_Mem_to_WB, Tuse_RAddr1_Mem_to_WB, Tnew_WAddr_Mem_to_WB,
           RAddr0_Mem, RAddr1_Mem, RegWriteAddr_Mem,
           Tuse_RAddr0_Mem, Tuse_RAddr1_Mem, Tnew_WAddr_Mem, bypass_Mem_out
  );

endinterface

// File: rtl/mem_stage_dm.sv
// Data memory: word array with byte-lane writes, same-cycle read and
// load extension selected by access size and sign flag.
module mem_stage_dm
  import mem_stage_pkg::*;
#(
  parameter  int DM_WORDS = 1024,
  localparam int AW       = $clog2(DM_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW+1:0]   addr_i,
  input  logic            we_i,
  input  acc_size_e       st_size_i,
  input  logic [31:0]     wdata_i,
  input  acc_size_e       ld_size_i,
  input  logic            ld_signed_i,
  output logic [31:0]     rdata_o
);

  logic [31:0]   mem_q [DM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   word_rd;
  logic [31:0]   wmask;
  logic [31:0]   wlane;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign idx     = addr_i[AW+1:2];
  assign off     = addr_i[1:0];
  assign word_rd = mem_q[idx];

  // Replicate the store data into every lane; the mask picks the live one
  always_comb begin
    wmask = '0;
    wlane = '0;
    case (st_size_i)
      ACC_WORD: begin
        wmask = 32'hFFFF_FFFF;
        wlane = wdata_i;
      end
      ACC_HALF: begin
        wmask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wlane = {2{wdata_i[15:0]}};
      end
      default: begin
        wmask = 32'h0000_00FF << {off, 3'b000};
        wlane = {4{wdata_i[7:0]}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[idx] <= (word_rd & ~wmask) | (wlane & wmask);
    end
  end

  assign byte_sel = word_rd[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    rdata_o = word_rd;
    case (ld_size_i)
      ACC_BYTE: rdata_o = ld_signed_i ? {{24{byte_sel[7]}}, byte_sel}
                                      : {24'h0, byte_sel};
      ACC_HALF: rdata_o = ld_signed_i ? {{16{half_sel[15]}}, half_sel}
                                      : {16'h0, half_sel};
      default:  rdata_o = word_rd;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: store-data forwarding mux, hazard counter
// decrement, data memory access and the Mem/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DM_WORDS = 1024,
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(DM_WORDS);

  logic [INSTR_W-1:0] instr;
  logic               is_load;
  logic               ld_signed;
  acc_size_e          ld_size;
  logic               st_en;
  acc_size_e          st_size;
  logic [31:0]        st_data;
  logic [31:0]        ld_data;
  logic [2:0]         tuse0_dec;
  logic [2:0]         tuse1_dec;
  logic [2:0]         tnew_dec;
  mem_wb_t            mem_wb_d;
  mem_wb_t            mem_wb_q;

  assign instr = bus.InstrType_EX_to_Mem;

  always_comb begin
    is_load   = 1'b0;
    ld_signed = 1'b0;
    ld_size   = ACC_WORD;
    if (instr[IDX_LW]) begin
      is_load = 1'b1;
    end else if (instr[IDX_LH]) begin
      is_load   = 1'b1;
      ld_size   = ACC_HALF;
      ld_signed = 1'b1;
    end else if (instr[IDX_LHU]) begin
      is_load = 1'b1;
      ld_size = ACC_HALF;
    end else if (instr[IDX_LB]) begin
      is_load   = 1'b1;
      ld_size   = ACC_BYTE;
      ld_signed = 1'b1;
    end else if (instr[IDX_LBU]) begin
      is_load = 1'b1;
      ld_size = ACC_BYTE;
    end
  end

  always_comb begin
    st_en   = 1'b0;
    st_size = ACC_WORD;
    if (instr[IDX_SW]) begin
      st_en = 1'b1;
    end else if (instr[IDX_SH]) begin
      st_en   = 1'b1;
      st_size = ACC_HALF;
    end else if (instr[IDX_SB]) begin
      st_en   = 1'b1;
      st_size = ACC_BYTE;
    end
  end

  // WB may still hold the producer of the store data
  assign st_data = (bus.DMWriteDataBypassCtrl_Mem == BYP_DM_WB) ? bus.bypass_WB
                                                                : bus.DMWriteData_EX_to_Mem;

  mem_stage_dm #(.DM_WORDS(DM_WORDS)) u_dm (
    .clk         (clk),
    .reset       (reset),
    .addr_i      (bus.ALUOut_EX_to_Mem[AW+1:0]),
    .we_i        (st_en),
    .st_size_i   (st_size),
    .wdata_i     (st_data),
    .ld_size_i   (ld_size),
    .ld_signed_i (ld_signed),
    .rdata_o     (ld_data)
  );

  assign tuse0_dec = sat_dec(bus.Tuse_RAddr0_EX_to_Mem);
  assign tuse1_dec = sat_dec(bus.Tuse_RAddr1_EX_to_Mem);
  assign tnew_dec  = sat_dec(bus.Tnew_WAddr_EX_to_Mem);

  assign bus.RAddr0_Mem       = bus.RAddr0_EX_to_Mem;
  assign bus.RAddr1_Mem       = bus.RAddr1_EX_to_Mem;
  assign bus.RegWriteAddr_Mem = bus.RegWriteAddr_EX_to_Mem;
  assign bus.Tuse_RAddr0_Mem  = tuse0_dec;
  assign bus.Tuse_RAddr1_Mem  = tuse1_dec;
  assign bus.Tnew_WAddr_Mem   = tnew_dec;
  assign bus.bypass_Mem_out   = bus.ALUOut_EX_to_Mem;

  always_comb begin
    mem_wb_d.pc     = bus.PC_EX_to_Mem;
    mem_wb_d.instr  = instr;
    mem_wb_d.waddr  = bus.RegWriteAddr_EX_to_Mem;
    mem_wb_d.wdata  = is_load ? ld_data : bus.ALUOut_EX_to_Mem;
    mem_wb_d.raddr0 = bus.RAddr0_EX_to_Mem;
    mem_wb_d.raddr1 = bus.RAddr1_EX_to_Mem;
    mem_wb_d.tuse0  = tuse0_dec;
    mem_wb_d.tuse1  = tuse1_dec;
    mem_wb_d.tnew   = tnew_dec;
  end

  // Reset leaves a bubble in WB whose sources look "never used"
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_q.pc     <= RESET_PC;
      mem_wb_q.instr  <= INST_SLL;
      mem_wb_q.waddr  <= '0;
      mem_wb_q.wdata  <= '0;
      mem_wb_q.raddr0 <= '0;
      mem_wb_q.raddr1 <= '0;
      mem_wb_q.tuse0  <= 3'b111;
      mem_wb_q.tuse1  <= 3'b111;
      mem_wb_q.tnew   <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.PC_Mem_to_WB           = mem_wb_q.pc;
  assign bus.InstrType_Mem_to_WB    = mem_wb_q.instr;
  assign bus.RegWriteAddr_Mem_to_WB = mem_wb_q.waddr;
  assign bus.RegWriteData_Mem_to_WB = mem_wb_q.wdata;
  assign bus.RAddr0_Mem_to_WB       = mem_wb_q.raddr0;
  assign bus.RAddr1_Mem_to_WB       = mem_wb_q.raddr1;
  assign bus.Tuse_RAddr0_Mem_to_WB  = mem_wb_q.tuse0;
  assign bus.Tuse_RAddr1_Mem_to_WB  = mem_wb_q.tuse1;
  assign bus.Tnew_WAddr_Mem_to_WB   = mem_wb_q.tnew;

endmodule
